axis_downsizer_scheduler: RTL and testbench
===========================================

Name: axis_downsizer_scheduler

Overview:
- Shares one axis_downsizer instance between NUM_PORTS wide AXI4-Stream sources.
- Arbitration is round-robin, with a per-port burst limit.
- Drives the downsizer's wide slave stream, its cfg_data word-count input and a channel tag.
- Changes cfg_data only while the downsizer is idle, so a word being serialised never sees a config change.

Parameters:
- NUM_PORTS, 4, number of requesting wide streams (2..16).
- S_AXIS_TDATA_WIDTH, 128, width of each source word and of the downsizer input.
- ID_WIDTH, 2, width of m_axis_tid; must be at least clog2(NUM_PORTS).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- cfg_data  in  NUM_PORTS*32  per port p, bits [32p+15:32p] = downsizer word count, bits [32p+31:32p+16] = burst length minus 1.
- s_axis_tdata  in  NUM_PORTS*S_AXIS_TDATA_WIDTH  source words; port p occupies slice p.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  S_AXIS_TDATA_WIDTH  to the downsizer's s_axis_tdata.
- m_axis_tvalid  out  1  to the downsizer's s_axis_tvalid.
- m_axis_tready  in  1  from the downsizer's s_axis_tready; high means the downsizer is idle and accepting.
- m_cfg_data  out  16  to the downsizer's cfg_data.
- m_axis_tid  out  ID_WIDTH  index of the granted port.

Behaviour:
- Reset (asynchronous, aresetn=0):
  - state=IDLE, grant=0, pointer=NUM_PORTS-1, so port 0 has first priority.
  - burst counter=0, m_cfg_data=0, m_axis_tid=0.
  - m_axis_tvalid=0, all s_axis_tready=0.
- States: IDLE, SEL, DRAIN.
- IDLE:
  - m_axis_tvalid=0; all s_axis_tready=0.
  - If any s_axis_tvalid is high: pick the first valid port searching upward from pointer+1 with wrap.
  - Register grant, pointer and m_axis_tid with that index.
  - Register m_cfg_data=cfg_data[32g+15:32g] and burst limit=cfg_data[32g+31:32g+16].
  - Clear the burst counter and go to SEL.
  - If no port is valid, stay in IDLE.
- SEL:
  - Combinational pass-through, zero latency:
    - m_axis_tdata = slice g;
    - m_axis_tvalid = s_axis_tvalid[g];
    - s_axis_tready[g] = m_axis_tready;
    - all other readys = 0.
  - On a handshake (valid & ready):
    - if counter == limit, go to DRAIN;
    - otherwise increment the counter.
  - If s_axis_tvalid[g]=0 in SEL with no handshake, go to DRAIN. An idle source releases the grant early.
- DRAIN:
  - m_axis_tvalid=0; all readys=0.
  - The downsizer may still be serialising the last word, so m_cfg_data is held.
  - When m_axis_tready=1, go to IDLE.
- Arbitration cadence: minimum gap between bursts is one DRAIN cycle plus one IDLE cycle.
- Burst limit field: value N allows N+1 words; 0 means a single word.
- Config sampling:
  - cfg_data is sampled only on the IDLE->SEL transition.
  - Changing cfg_data during SEL or DRAIN has no effect until the next grant.
- m_cfg_data and m_axis_tid are stable from SEL entry until the next IDLE->SEL transition.
- Word count 0 is allowed (downsizer pass-through; tready stays high) and needs no special case.
- Simultaneous requests are resolved by the rotation order only. A port just served has lowest priority next time.
- Single requester: the same port is re-granted after each DRAIN/IDLE pair.
- Source dropping tvalid mid-burst ends that burst. The AXI rule is still met, because a beat is dropped only if it was never offered.
- Reset mid-burst forces IDLE immediately. Any beat not yet accepted is not counted; the downsizer is reset by the same aresetn.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, SEL, DRAIN);
  - cfg field offsets and widths: WC_LSB=0, WC_WIDTH=16, BL_LSB=16, BL_WIDTH=16, CFG_STRIDE=32.
- One sub-module, rr_arbiter_pick: combinational round-robin priority encoder.
  - Inputs: request vector, pointer.
  - Outputs: grant index, any_request flag.
- The FSM, counters, config registers and datapath mux stay in the top.

Test Plan:
1. Reset then a single request:
   - Stimulus: port 2 valid, cfg word count 3, burst field 1.
   - Required: m_axis_tid=2 and m_cfg_data=3 one cycle after the request. Exactly 2 words are passed, then DRAIN holds until the downsizer ready returns.
2. All four ports valid continuously, burst field 0:
   - Required: grant order 0,1,2,3,0. Each grant carries one word, and m_cfg_data switches only in cycles where m_axis_tready was 1.
3. Backpressure:
   - Stimulus: downsizer ready low for 5 cycles mid-burst, burst field 3.
   - Required: data and valid held stable, no word lost or duplicated, exactly 4 words counted.
4. Early release:
   - Stimulus: port 1 drops tvalid after 2 of 8 burst words.
   - Required: DRAIN entered, and port 3 (pending) granted next.
5. Config change mid-burst:
   - Stimulus: cfg for the granted port 0 changed from word count 3 to 1 during SEL.
   - Required: m_cfg_data stays 3 until the next grant of port 0, which shows 1.
6. Asynchronous reset:
   - Stimulus: aresetn asserted between clock edges during SEL.
   - Required: m_axis_tvalid and all readys drop immediately. Port 0 has first priority after release.

Source files
------------

// File: rtl/axis_downsizer_scheduler_pkg.sv
// Shared types and config-word layout for the downsizer scheduler.
// Each port owns one 32-bit config word: word count low, burst length minus 1 high.
package axis_downsizer_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSel,
    StDrain
  } sched_state_e;

  localparam int unsigned WC_LSB     = 0;
  localparam int unsigned WC_WIDTH   = 16;
  localparam int unsigned BL_LSB     = 16;
  localparam int unsigned BL_WIDTH   = 16;
  localparam int unsigned CFG_STRIDE = 32;

  function automatic logic [WC_WIDTH-1:0] cfg_wc(input logic [CFG_STRIDE-1:0] word);
    return word[WC_LSB +: WC_WIDTH];
  endfunction

  function automatic logic [BL_WIDTH-1:0] cfg_bl(input logic [CFG_STRIDE-1:0] word);
    return word[BL_LSB +: BL_WIDTH];
  endfunction

endpackage

// File: rtl/axis_downsizer_scheduler_if.sv
// Bundle of the wide source streams plus the stream/config/tag driven into the downsizer.
// master = the scheduler itself, slave = the sources and downsizer around it.
interface axis_downsizer_scheduler_if
  import axis_downsizer_scheduler_pkg::*;
#(
  parameter int unsigned NUM_PORTS          = 4,
  parameter int unsigned S_AXIS_TDATA_WIDTH = 128,
  parameter int unsigned ID_WIDTH           = 2
) ();

  logic [NUM_PORTS*S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS-1:0]                    s_axis_tvalid;
  logic [NUM_PORTS-1:0]                    s_axis_tready;
  logic [S_AXIS_TDATA_WIDTH-1:0]           m_axis_tdata;
  logic                                    m_axis_tvalid;
  logic                                    m_axis_tready;
  logic [WC_WIDTH-1:0]                     m_cfg_data;
  logic [ID_WIDTH-1:0]                     m_axis_tid;

  modport master (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  m_axis_tready,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_cfg_data,
    output m_axis_tid
  );

  modport slave (
    output s_axis_tdata,
    output s_axis_tvalid,
    output m_axis_tready,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_cfg_data,
    input  m_axis_tid
  );

endinterface

// File: rtl/axis_downsizer_scheduler_rr_arbiter_pick.sv
// Combinational round-robin pick: first asserted request searching upward from
// ptr_i+1 with wrap, so the port at ptr_i itself has the lowest priority.
module rr_arbiter_pick #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW  = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   grant_o,
  output logic              any_req_o
);

  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand     = (32'(ptr_i) + i) % NumReq;
      cand_idx = IdxW'(cand);
      if (!any_req_o && req_i[cand_idx]) begin
        grant_o   = cand_idx;
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_downsizer_scheduler.sv
// Round-robin scheduler sharing one axis_downsizer between several wide sources.
// The word-count config is only re-registered while the downsizer reports idle.
module axis_downsizer_scheduler
  import axis_downsizer_scheduler_pkg::*;
#(
  parameter int unsigned NUM_PORTS          = 4,
  parameter int unsigned S_AXIS_TDATA_WIDTH = 128,
  parameter int unsigned ID_WIDTH           = 2
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_PORTS*CFG_STRIDE-1:0] cfg_data,
  axis_downsizer_scheduler_if.master      bus
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);

  sched_state_e state_q, state_d;

  logic [IdxW-1:0]     grant_q, grant_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [ID_WIDTH-1:0] tid_q, tid_d;
  logic [WC_WIDTH-1:0] wc_q, wc_d;
  logic [BL_WIDTH-1:0] limit_q, limit_d;
  logic [BL_WIDTH-1:0] cnt_q, cnt_d;

  logic [IdxW-1:0]       pick_idx;
  logic                  pick_any;
  logic [CFG_STRIDE-1:0] pick_cfg;
  logic                  gnt_valid;
  logic                  hs;

  rr_arbiter_pick #(
    .NumReq (NUM_PORTS)
  ) u_pick (
    .req_i     (bus.s_axis_tvalid),
    .ptr_i     (ptr_q),
    .grant_o   (pick_idx),
    .any_req_o (pick_any)
  );

  assign pick_cfg  = cfg_data[CFG_STRIDE*pick_idx +: CFG_STRIDE];
  assign gnt_valid = bus.s_axis_tvalid[grant_q];
  assign hs        = (state_q == StSel) && gnt_valid && bus.m_axis_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) state_d = StSel;
      end
      StSel: begin
        // An idle source gives up the grant rather than stalling the others.
        if (hs) begin
          if (cnt_q == limit_q) state_d = StDrain;
        end else if (!gnt_valid) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (bus.m_axis_tready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.m_axis_tdata  = bus.s_axis_tdata[grant_q*S_AXIS_TDATA_WIDTH +: S_AXIS_TDATA_WIDTH];
    bus.m_axis_tvalid = 1'b0;
    bus.s_axis_tready = '0;
    bus.m_cfg_data    = wc_q;
    bus.m_axis_tid    = tid_q;
    if (state_q == StSel) begin
      bus.m_axis_tvalid          = gnt_valid;
      bus.s_axis_tready[grant_q] = bus.m_axis_tready;
    end
  end

  // Config and tag are captured only on the grant, so they stay put through DRAIN.
  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
    tid_d   = tid_q;
    wc_d    = wc_q;
    limit_d = limit_q;
    cnt_d   = cnt_q;
    if (state_q == StIdle && pick_any) begin
      grant_d = pick_idx;
      ptr_d   = pick_idx;
      tid_d   = ID_WIDTH'(pick_idx);
      wc_d    = cfg_wc(pick_cfg);
      limit_d = cfg_bl(pick_cfg);
      cnt_d   = '0;
    end else if (hs && cnt_q != limit_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant_q <= '0;
      ptr_q   <= IdxW'(NUM_PORTS - 1);
      tid_q   <= '0;
      wc_q    <= '0;
      limit_q <= '0;
      cnt_q   <= '0;
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      tid_q   <= tid_d;
      wc_q    <= wc_d;
      limit_q <= limit_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_downsizer_scheduler.sv
// Directed bench for axis_downsizer_scheduler: per-cycle vector table plus
// hand-written backpressure and asynchronous-reset sequences.
module tb_axis_downsizer_scheduler;
  import axis_downsizer_scheduler_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 128;
  localparam int unsigned IW = 2;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [NP*32-1:0] cfg_data;

  always #5 aclk = ~aclk;

  axis_downsizer_scheduler_if #(
    .NUM_PORTS          (NP),
    .S_AXIS_TDATA_WIDTH (DW),
    .ID_WIDTH           (IW)
  ) bus ();

  axis_downsizer_scheduler #(
    .NUM_PORTS          (NP),
    .S_AXIS_TDATA_WIDTH (DW),
    .ID_WIDTH           (IW)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .cfg_data (cfg_data),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         rst;
    logic [127:0] cfg;
    logic [3:0] sv;
    logic       mr;
    logic       emv;
    logic [3:0] esr;
    logic [1:0] etid;
    logic [15:0] ecfg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pc(input int unsigned bl, input int unsigned wc);
    return {bl[15:0], wc[15:0]};
  endfunction

  function automatic logic [DW-1:0] pword(input int unsigned p);
    return DW'(32'hA5A5_0000 + p);
  endfunction

  function automatic vec_t mk(input bit rst, input logic [127:0] cfg, input logic [3:0] sv,
                              input logic mr, input logic emv, input logic [3:0] esr,
                              input logic [1:0] etid, input logic [15:0] ecfg);
    vec_t v;
    v.rst = rst; v.cfg = cfg; v.sv = sv; v.mr = mr;
    v.emv = emv; v.esr = esr; v.etid = etid; v.ecfg = ecfg;
    return v;
  endfunction

  task automatic set_data();
    for (int p = 0; p < NP; p++) bus.s_axis_tdata[p*DW +: DW] = pword(p);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    bus.s_axis_tvalid = '0;
    bus.m_axis_tready = 1'b1;
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [127:0] c1, c2, c4, c5a, c5b, c3, c6;
    int accepted;

    aresetn = 1'b0;
    cfg_data = '0;
    bus.s_axis_tvalid = '0;
    bus.m_axis_tready = 1'b1;
    set_data();

    c1  = {pc(0, 0), pc(1, 3), pc(0, 0), pc(0, 0)};
    c2  = {pc(0, 7), pc(0, 6), pc(0, 5), pc(0, 4)};
    c4  = {pc(0, 2), pc(0, 0), pc(7, 9), pc(0, 0)};
    c5a = {pc(0, 0), pc(0, 0), pc(0, 0), pc(0, 3)};
    c5b = {pc(0, 0), pc(0, 0), pc(0, 0), pc(0, 1)};

    // Single requester on port 2: two words, then DRAIN held while the downsizer is busy.
    vecs.push_back(mk(1, c1, 4'b0100, 1, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, c1, 4'b0100, 1, 1, 4'b0100, 2, 3));
    vecs.push_back(mk(0, c1, 4'b0100, 1, 1, 4'b0100, 2, 3));
    vecs.push_back(mk(0, c1, 4'b0100, 0, 0, 4'b0000, 2, 3));
    vecs.push_back(mk(0, c1, 4'b0100, 0, 0, 4'b0000, 2, 3));
    vecs.push_back(mk(0, c1, 4'b0000, 1, 0, 4'b0000, 2, 3));
    vecs.push_back(mk(0, c1, 4'b0000, 1, 0, 4'b0000, 2, 3));
    // All ports valid, one word each: rotation 0,1,2,3,0.
    vecs.push_back(mk(1, c2, 4'b1111, 1, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, c2, 4'b1111, 1, 1, 4'b0001, 0, 4));
    vecs.push_back(mk(0, c2, 4'b1111, 1, 0, 4'b0000, 0, 4));
    vecs.push_back(mk(0, c2, 4'b1111, 1, 0, 4'b0000, 0, 4));
    vecs.push_back(mk(0, c2, 4'b1111, 1, 1, 4'b0010, 1, 5));
    vecs.push_back(mk(0, c2, 4'b1111, 1, 0, 4'b0000, 1, 5));
    vecs.push_back(mk(0, c2, 4'b1111, 1, 0, 4'b0000, 1, 5));
    vecs.push_back(mk(0, c2, 4'b1111, 1, 1, 4'b0100, 2, 6));
    vecs.push_back(mk(0, c2, 4'b1111, 1, 0, 4'b0000, 2, 6));
    vecs.push_back(mk(0, c2, 4'b1111, 1, 0, 4'b0000, 2, 6));
    vecs.push_back(mk(0, c2, 4'b1111, 1, 1, 4'b1000, 3, 7));
    vecs.push_back(mk(0, c2, 4'b1111, 1, 0, 4'b0000, 3, 7));
    vecs.push_back(mk(0, c2, 4'b1111, 1, 0, 4'b0000, 3, 7));
    vecs.push_back(mk(0, c2, 4'b1111, 1, 1, 4'b0001, 0, 4));
    // Port 1 drops valid after 2 of 8 words; pending port 3 is served next.
    vecs.push_back(mk(1, c4, 4'b1010, 1, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, c4, 4'b1010, 1, 1, 4'b0010, 1, 9));
    vecs.push_back(mk(0, c4, 4'b1010, 1, 1, 4'b0010, 1, 9));
    vecs.push_back(mk(0, c4, 4'b1000, 1, 0, 4'b0010, 1, 9));
    vecs.push_back(mk(0, c4, 4'b1000, 1, 0, 4'b0000, 1, 9));
    vecs.push_back(mk(0, c4, 4'b1000, 1, 0, 4'b0000, 1, 9));
    vecs.push_back(mk(0, c4, 4'b1000, 1, 1, 4'b1000, 3, 2));
    // Config for port 0 rewritten during SEL: visible only at the next grant.
    vecs.push_back(mk(1, c5a, 4'b0001, 1, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, c5b, 4'b0001, 1, 1, 4'b0001, 0, 3));
    vecs.push_back(mk(0, c5b, 4'b0001, 1, 0, 4'b0000, 0, 3));
    vecs.push_back(mk(0, c5b, 4'b0001, 1, 0, 4'b0000, 0, 3));
    vecs.push_back(mk(0, c5b, 4'b0001, 1, 1, 4'b0001, 0, 1));

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      @(negedge aclk);
      cfg_data          = vecs[i].cfg;
      bus.s_axis_tvalid = vecs[i].sv;
      bus.m_axis_tready = vecs[i].mr;
      #1;
      check($sformatf("v%0d m_axis_tvalid", i), bus.m_axis_tvalid, vecs[i].emv);
      check($sformatf("v%0d s_axis_tready", i), bus.s_axis_tready, vecs[i].esr);
      check($sformatf("v%0d m_axis_tid", i), bus.m_axis_tid, vecs[i].etid);
      check($sformatf("v%0d m_cfg_data", i), bus.m_cfg_data, vecs[i].ecfg);
      if (vecs[i].emv) check($sformatf("v%0d m_axis_tdata", i), bus.m_axis_tdata,
                             pword(vecs[i].etid));
    end

    // Backpressure: ready low for 5 cycles mid-burst, burst of 4 words.
    c3 = {pc(0, 0), pc(0, 0), pc(0, 0), pc(3, 2)};
    cfg_data = c3;
    do_reset();
    accepted = 0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge aclk);
      bus.s_axis_tdata[0 +: DW] = DW'(32'hD000_0000 + accepted);
      bus.s_axis_tvalid = 4'b0001;
      bus.m_axis_tready = !(c >= 3 && c <= 7);
      #1;
      if (c >= 1 && c <= 9) check($sformatf("bp c%0d m_axis_tvalid", c), bus.m_axis_tvalid, 1);
      if (c == 10) check("bp drain m_axis_tvalid", bus.m_axis_tvalid, 0);
      if (bus.m_axis_tvalid)
        check($sformatf("bp c%0d m_axis_tdata", c), bus.m_axis_tdata,
              DW'(32'hD000_0000 + accepted));
      if (bus.s_axis_tready[0]) accepted++;
    end
    check("bp words accepted", 128'(accepted), 4);
    bus.s_axis_tvalid = '0;
    set_data();

    // Asynchronous reset between edges while port 2 holds the grant.
    c6 = {pc(0, 0), pc(3, 5), pc(0, 0), pc(3, 4)};
    cfg_data = c6;
    do_reset();
    @(negedge aclk);
    bus.s_axis_tvalid = 4'b0100;
    bus.m_axis_tready = 1'b1;
    #1;
    check("ar idle m_axis_tvalid", bus.m_axis_tvalid, 0);
    @(negedge aclk);
    bus.s_axis_tvalid = 4'b0101;
    #1;
    check("ar sel m_axis_tvalid", bus.m_axis_tvalid, 1);
    check("ar sel m_axis_tid", bus.m_axis_tid, 2);
    #2;
    aresetn = 1'b0;
    #1;
    check("ar rst m_axis_tvalid", bus.m_axis_tvalid, 0);
    check("ar rst s_axis_tready", bus.s_axis_tready, 0);
    check("ar rst m_axis_tid", bus.m_axis_tid, 0);
    check("ar rst m_cfg_data", bus.m_cfg_data, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    check("ar post m_axis_tid", bus.m_axis_tid, 0);
    check("ar post m_axis_tvalid", bus.m_axis_tvalid, 1);
    check("ar post s_axis_tready", bus.s_axis_tready, 4'b0001);
    check("ar post m_cfg_data", bus.m_cfg_data, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
